extmem_ctlr: RTL

Parametrised external-memory controller that bridges a CPU-side word port to a narrower external memory link. It splits each CPU access into BEATS = CPU_WIDTH/LINK_WIDTH sequential link beats, applies a programmable number of wait states plus an optional device-ready stretch, and reassembles read data. It sits between the core's data or instruction port and the board RAM/ROM link. It generalises the fixed 32-to-16 RAM/ROM controllers to any width ratio, and adds byte strobes, wait states and a req/ack handshake.

---
 rtl/extmem_ctlr.sv | 137 +++++++++++++
 1 files changed

// File: rtl/extmem_ctlr.sv
// CPU-word to narrow external-link bridge: splits each access into BEATS link beats
// with programmable wait states and a device-ready stretch, then reassembles read data.
module extmem_ctlr #(
    parameter int ADDR_WIDTH  = 32,
    parameter int CPU_WIDTH   = 32,
    parameter int LINK_WIDTH  = 16,
    parameter int WAIT_STATES = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cpu_req,
    input  logic                    cpu_we,
    input  logic [ADDR_WIDTH-1:0]   cpu_addr,
    input  logic [CPU_WIDTH-1:0]    cpu_wdata,
    input  logic [CPU_WIDTH/8-1:0]  cpu_be,
    output logic [CPU_WIDTH-1:0]    cpu_rdata,
    output logic                    cpu_ack,
    output logic                    busy,
    output logic [ADDR_WIDTH-1:0]   link_addr,
    output logic [LINK_WIDTH-1:0]   link_wdata,
    input  logic [LINK_WIDTH-1:0]   link_rdata,
    output logic [LINK_WIDTH/8-1:0] link_be,
    output logic                    link_cs,
    output logic                    link_we,
    input  logic                    link_rdy
);

    localparam int BEATS  = CPU_WIDTH / LINK_WIDTH;
    localparam int BE_W   = CPU_WIDTH / 8;
    localparam int LBE_W  = LINK_WIDTH / 8;
    localparam int OFFSET = $clog2(CPU_WIDTH / 8);
    localparam int BW     = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
    localparam logic [3:0]    WAIT_MAX  = 4'(WAIT_STATES);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t                state, state_next;
    logic [ADDR_WIDTH-1:0] base_q, base_next;
    logic                  we_q, we_next;
    logic [CPU_WIDTH-1:0]  wdata_q, wdata_next;
    logic [BE_W-1:0]       be_q, be_next;
    logic [BW-1:0]         beat_q, beat_next;
    logic [3:0]            wait_q, wait_next;
    logic [CPU_WIDTH-1:0]  shadow_q, shadow_next;
    logic [CPU_WIDTH-1:0]  rdata_q, rdata_next;
    logic [ADDR_WIDTH-1:0] req_base;

    // First link-word address of the requested CPU word; wraps modulo 2^ADDR_WIDTH.
    assign req_base = ADDR_WIDTH'((cpu_addr >> OFFSET) * BEATS);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            base_q   <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            be_q     <= '0;
            beat_q   <= '0;
            wait_q   <= '0;
            shadow_q <= '0;
            rdata_q  <= '0;
        end else begin
            state    <= state_next;
            base_q   <= base_next;
            we_q     <= we_next;
            wdata_q  <= wdata_next;
            be_q     <= be_next;
            beat_q   <= beat_next;
            wait_q   <= wait_next;
            shadow_q <= shadow_next;
            rdata_q  <= rdata_next;
        end
    end

    always_comb begin
        state_next  = state;
        base_next   = base_q;
        we_next     = we_q;
        wdata_next  = wdata_q;
        be_next     = be_q;
        beat_next   = beat_q;
        wait_next   = wait_q;
        shadow_next = shadow_q;
        rdata_next  = rdata_q;
        case (state)
            IDLE: begin
                if (cpu_req) begin
                    base_next  = req_base;
                    we_next    = cpu_we;
                    wdata_next = cpu_wdata;
                    be_next    = cpu_be;
                    beat_next  = '0;
                    wait_next  = '0;
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                if (wait_q < WAIT_MAX) begin
                    wait_next = wait_q + 4'd1;
                end else if (link_rdy) begin
                    wait_next = '0;
                    if (!we_q) begin
                        shadow_next[beat_q*LINK_WIDTH +: LINK_WIDTH] = link_rdata;
                    end
                    // Last beat: publish the assembled word on the edge entering DONE.
                    if (beat_q == LAST_BEAT) begin
                        state_next = DONE;
                        if (!we_q) begin
                            rdata_next = shadow_next;
                        end
                    end else begin
                        beat_next = beat_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign link_cs    = (state == ACCESS);
    assign link_we    = link_cs & we_q;
    assign link_addr  = base_q + ADDR_WIDTH'(beat_q);
    assign link_wdata = wdata_q[beat_q*LINK_WIDTH +: LINK_WIDTH];
    assign link_be    = !link_cs ? '0 :
                        (we_q ? be_q[beat_q*LBE_W +: LBE_W] : {LBE_W{1'b1}});
    assign cpu_ack    = (state == DONE);
    assign busy       = (state != IDLE);
    assign cpu_rdata  = rdata_q;

endmodule
